// File: rtl/sample_pkg.sv
// Shared types and constants for the sample playback source.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sample_pkg;

    localparam int N_DEF   = 16;
    localparam int K_DEF   = 42;
    localparam int STALL_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        HOLD,
        DONE
    } state_t;

    // Ceiling log2, used to size the buffer index from the depth.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_buf.sv
// K x N sample storage: synchronous write port, asynchronous read port.
// Latency: write visible on the following cycle; read is combinational.
// Backpressure: none; the caller gates wr_en.
module sample_buf
    import sample_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF,
    localparam int AW = clog2(K)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_data
);

    logic [N-1:0] mem [K];

    // Storage is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_streamer.sv
// Plays a K-entry signed sample buffer out one sample per clock, one-shot or looped.
// Latency: first sample valid one cycle after the start edge, then one per cycle.
// Backpressure: stop=1 holds the current sample and index; nothing is skipped or repeated.
module sample_streamer
    import sample_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF,
    localparam int AW = clog2(K)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [N-1:0]       wr_data,
    input  logic               start,
    input  logic               loop,
    input  logic               abort,
    input  logic               stop,
    output logic               ready,
    output logic [N-1:0]       data_out,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      sample_idx,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam logic [AW-1:0] LAST_IDX = AW'(K - 1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(K);

    state_t              state_q, state_d;
    logic [AW-1:0]       idx_d;
    logic                ready_d;
    logic [N-1:0]        data_d;
    logic                busy_d;
    logic                done_d;
    logic [STALL_W-1:0]  stall_d;
    logic [N-1:0]        rd_data;
    logic                buf_we;

    // Writes only land while idle and in range; busy-time writes vanish silently.
    assign buf_we = wr_en && !busy && ({1'b0, wr_addr} < DEPTH);

    sample_buf #(
        .N (N),
        .K (K)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (sample_idx),
        .rd_data (rd_data)
    );

    // Next-state and next-output decode; abort overrides every state.
    always_comb begin
        state_d = state_q;
        idx_d   = sample_idx;
        ready_d = 1'b0;
        data_d  = data_out;
        busy_d  = busy;
        done_d  = 1'b0;
        stall_d = stall_cnt;
        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = STREAM;
                        idx_d   = '0;
                        stall_d = '0;
                        busy_d  = 1'b1;
                    end
                end
                STREAM, HOLD: begin
                    if (stop) begin
                        state_d = HOLD;
                        if (stall_cnt != '1) begin
                            stall_d = stall_cnt + 1'b1;
                        end
                    end else begin
                        ready_d = 1'b1;
                        data_d  = rd_data;
                        if (sample_idx == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = loop ? STREAM : DONE;
                        end else begin
                            idx_d   = sample_idx + 1'b1;
                            state_d = STREAM;
                        end
                    end
                end
                DONE: begin
                    // First DONE cycle shows the last sample; the second raises done.
                    if (!done) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sample_idx <= '0;
            ready      <= 1'b0;
            data_out   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            sample_idx <= idx_d;
            ready      <= ready_d;
            data_out   <= data_d;
            busy       <= busy_d;
            done       <= done_d;
            stall_cnt  <= stall_d;
        end
    end

endmodule

// File: tb/tb_sample_streamer.sv
// Scoreboard bench for sample_streamer: stimulus queues expected samples, a monitor checks them.
// Latency: checks sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: stop is exercised directly by the stimulus.
module tb_sample_streamer;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        loop;
    logic        abort;
    logic        stop;
    logic        ready;
    logic [15:0] data_out;
    logic        busy;
    logic        done;
    logic [5:0]  sample_idx;
    logic [7:0]  stall_cnt;

    int exp_q[$];
    int total = 0;
    int bad = 0;
    int ready_cnt = 0;
    int rises = 0;
    int done_cnt = 0;
    bit last_ready = 1'b0;
    int last_data = 0;

    sample_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .loop       (loop),
        .abort      (abort),
        .stop       (stop),
        .ready      (ready),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .sample_idx (sample_idx),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every ready cycle pops one expected sample.
    always @(negedge clk) begin
        if (ready) begin
            ready_cnt++;
            if (!last_ready) rises++;
            if (exp_q.size() == 0) begin
                chk("unexpected_sample", $signed(data_out), 99999);
            end else begin
                chk("sample", $signed(data_out), exp_q.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            chk("done_after_last", (last_ready && last_data == 20) ? 1 : 0, 1);
        end
        last_ready = ready;
        last_data  = $signed(data_out);
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 42; i++) begin
            wr_en   = 1'b1;
            wr_addr = 6'(i);
            wr_data = 16'(i - 21);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic push_ramp(input int from_idx);
        for (int i = from_idx; i < 42; i++) exp_q.push_back(i - 21);
    endtask

    task automatic clear_stats();
        ready_cnt = 0;
        rises     = 0;
        done_cnt  = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int found;
        found = 0;
        for (int c = 0; c < 300 && found == 0; c++) begin
            @(negedge clk);
            if (done) found = 1;
        end
        chk(name, found, 1);
        tick();
    endtask

    task automatic wait_sample(input string name, input int val);
        int found;
        found = 0;
        for (int c = 0; c < 300 && found == 0; c++) begin
            @(negedge clk);
            if (ready && $signed(data_out) == val) found = 1;
        end
        chk(name, found, 1);
    endtask

    task automatic wait_idx(input string name, input int idx);
        int found;
        found = 0;
        for (int c = 0; c < 300 && found == 0; c++) begin
            @(negedge clk);
            if (int'(sample_idx) == idx) found = 1;
        end
        chk(name, found, 1);
    endtask

    task automatic run_end(input string name, input int n_ready, input int n_rises, input int n_done);
        chk({name, "_ready_cnt"}, ready_cnt, n_ready);
        chk({name, "_ready_runs"}, rises, n_rises);
        chk({name, "_done_cnt"}, done_cnt, n_done);
        chk({name, "_queue_left"}, exp_q.size(), 0);
        chk({name, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; loop = 1'b0; abort = 1'b0; stop = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_ready", int'(ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_idx", int'(sample_idx), 0);
        chk("rst_stall", int'(stall_cnt), 0);
        chk("rst_data", int'(data_out), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1: one-shot run
        load_ramp();
        clear_stats();
        push_ramp(0);
        pulse_start();
        chk("t1_busy_after_start", int'(busy), 1);
        chk("t1_no_ready_yet", int'(ready), 0);
        tick();
        chk("t1_first_ready", int'(ready), 1);
        wait_done("t1_done_seen");
        run_end("t1", 42, 1, 1);
        chk("t1_stall", int'(stall_cnt), 0);

        // 2: backpressure after idx 5 (value -16)
        clear_stats();
        push_ramp(0);
        pulse_start();
        wait_sample("t2_saw_m16", -16);
        stop = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t2_ready_held_low", int'(ready), 0);
        chk("t2_idx_held", int'(sample_idx), 6);
        chk("t2_stall_mid", int'(stall_cnt), 3);
        stop = 1'b0;
        tick();
        chk("t2_resume_data", $signed(data_out), -15);
        wait_done("t2_done_seen");
        run_end("t2", 42, 2, 1);
        chk("t2_stall", int'(stall_cnt), 3);

        // 3: looping, then clear loop on the second pass
        clear_stats();
        push_ramp(0);
        push_ramp(0);
        loop = 1'b1;
        pulse_start();
        wait_sample("t3_saw_20", 20);
        @(negedge clk);
        chk("t3_wrap_ready", int'(ready), 1);
        chk("t3_wrap_data", $signed(data_out), -21);
        chk("t3_wrap_idx", int'(sample_idx), 1);
        chk("t3_wrap_nodone", int'(done), 0);
        loop = 1'b0;
        wait_done("t3_done_seen");
        run_end("t3", 84, 1, 1);

        // 4: abort at sample_idx 10, then restart
        clear_stats();
        push_ramp(0);
        while (exp_q.size() > 10) void'(exp_q.pop_back());
        pulse_start();
        wait_idx("t4_reach_idx10", 10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_ready", int'(ready), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_idx", int'(sample_idx), 0);
        tick();
        tick();
        chk("t4_done_cnt", done_cnt, 0);
        chk("t4_ready_cnt", ready_cnt, 10);
        chk("t4_queue_left", exp_q.size(), 0);
        clear_stats();
        push_ramp(0);
        pulse_start();
        wait_done("t4_restart_done");
        run_end("t4r", 42, 1, 1);

        // 5: async reset between edges at idx 20
        clear_stats();
        push_ramp(0);
        while (exp_q.size() > 20) void'(exp_q.pop_back());
        pulse_start();
        wait_idx("t5_reach_idx20", 20);
        #1 rst = 1'b1;
        #1;
        chk("t5_ready", int'(ready), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_data", int'(data_out), 0);
        chk("t5_idx", int'(sample_idx), 0);
        #1 rst = 1'b0;
        tick();
        chk("t5_queue_left", exp_q.size(), 0);
        clear_stats();
        push_ramp(0);
        pulse_start();
        wait_done("t5_restart_done");
        run_end("t5r", 42, 1, 1);

        // 6: guarding of writes and start while busy, out-of-range write
        clear_stats();
        push_ramp(0);
        pulse_start();
        tick();
        tick();
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 16'h7FFF; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        wait_done("t6a_done");
        run_end("t6a", 42, 1, 1);
        wr_en = 1'b1; wr_addr = 6'd45; wr_data = 16'h1234;
        tick();
        wr_en = 1'b0;
        clear_stats();
        push_ramp(0);
        pulse_start();
        wait_done("t6b_done");
        run_end("t6b", 42, 1, 1);

        // write and start on the same idle edge: the run sees the new value
        clear_stats();
        exp_q.push_back(100);
        push_ramp(1);
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = 16'd100;
        pulse_start();
        wr_en = 1'b0;
        wait_done("t6c_done");
        run_end("t6c", 42, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
